// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC core: tree geometry, requester id sizing and the tag
// record that travels alongside each vector through the adder tree.
package mac_pkg;

    localparam int unsigned MAC_DIN_W    = 2304;
    localparam int unsigned MAC_ACC_W    = 8;
    localparam int unsigned MAC_TREE_LAT = 8;

    // Tags carry the widest id (8 requesters) so one type serves every NUM_REQ.
    localparam int unsigned MAC_MAX_ID_W = 3;

    function automatic int unsigned req_id_w(input int unsigned n);
        return $clog2(n);
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [MAC_MAX_ID_W-1:0] id;
    } mac_tag_t;

endpackage

// File: rtl/mac_tree_arbiter_if.sv
// Requester and adder-tree signals of the MAC tree arbiter; slave is the arbiter side,
// master is the requesters plus tree side.
interface mac_tree_arbiter_if
    import mac_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DIN_W   = MAC_DIN_W,
    parameter int unsigned ACC_W   = MAC_ACC_W
) ();

    logic [NUM_REQ-1:0]       req_vld;
    logic [NUM_REQ*DIN_W-1:0] req_din;
    logic [NUM_REQ-1:0]       req_rdy;
    logic                     tree_vld_i;
    logic [DIN_W-1:0]         tree_din;
    logic                     tree_vld_o;
    logic [ACC_W-1:0]         tree_acc;
    logic [NUM_REQ-1:0]       rsp_vld;
    logic [ACC_W-1:0]         rsp_acc;

    modport master (
        output req_vld, req_din, tree_vld_o, tree_acc,
        input  req_rdy, tree_vld_i, tree_din, rsp_vld, rsp_acc
    );

    modport slave (
        input  req_vld, req_din, tree_vld_o, tree_acc,
        output req_rdy, tree_vld_i, tree_din, rsp_vld, rsp_acc
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr with wrap-around;
// ptr moves past the granted requester whenever a transfer happens.
module rr_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N-1:0]           req,
    input  logic                   en,
    input  logic                   advance,
    output logic [N-1:0]           gnt,
    output logic [req_id_w(N)-1:0] gnt_id
);

    localparam int unsigned ID_W = req_id_w(N);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] idx;
    logic            found;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= N) s = s - N;
        return ID_W'(s);
    endfunction

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = wrap_add(ptr_q, k);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/mac_tree_arbiter.sv
// Shares one pipelined MAC adder tree among NUM_REQ requesters: arbitrates, registers the issued
// vector, tracks its requester through a tag line and routes the tree result back.
module mac_tree_arbiter
    import mac_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DIN_W    = MAC_DIN_W,
    parameter int unsigned ACC_W    = MAC_ACC_W,
    parameter int unsigned TREE_LAT = MAC_TREE_LAT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    output logic               idle,
    output logic               err,
    mac_tree_arbiter_if.slave  bus
);

    localparam int unsigned ID_W = req_id_w(NUM_REQ);

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_id;
    logic                transfer;
    logic [DIN_W-1:0]    sel_din;

    logic                tree_vld_q;
    logic [DIN_W-1:0]    tree_din_q;
    logic [ID_W-1:0]     issue_id_q;

    mac_tag_t            tag_q [TREE_LAT];
    mac_tag_t            last_tag;
    logic [TREE_LAT-1:0] tag_valids;

    logic [NUM_REQ-1:0]  rsp_hot;
    logic [NUM_REQ-1:0]  rsp_vld_q;
    logic [ACC_W-1:0]    rsp_acc_q;
    logic                err_q;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rstn    (rstn),
        .req     (bus.req_vld),
        .en      (en),
        .advance (transfer),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    assign bus.req_rdy = gnt;
    assign transfer    = |(bus.req_vld & gnt);

    always_comb begin
        sel_din = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) sel_din = bus.req_din[i*DIN_W +: DIN_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tree_vld_q <= 1'b0;
            tree_din_q <= '0;
            issue_id_q <= '0;
        end else begin
            tree_vld_q <= transfer;
            if (transfer) begin
                tree_din_q <= sel_din;
                issue_id_q <= gnt_id;
            end
        end
    end

    // Stage TREE_LAT-1 lines up with tree_vld_o for the vector issued TREE_LAT cycles earlier.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < TREE_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: tree_vld_q, id: MAC_MAX_ID_W'(issue_id_q)};
            for (int unsigned i = 1; i < TREE_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_comb begin
        last_tag   = tag_q[TREE_LAT-1];
        tag_valids = '0;
        for (int unsigned i = 0; i < TREE_LAT; i++) tag_valids[i] = tag_q[i].valid;
        rsp_hot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (last_tag.id == MAC_MAX_ID_W'(i)) rsp_hot[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_vld_q <= '0;
            rsp_acc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (bus.tree_vld_o && last_tag.valid) begin
                rsp_vld_q <= rsp_hot;
                rsp_acc_q <= bus.tree_acc;
            end else begin
                rsp_vld_q <= '0;
            end
            // Result without a tag, or a tag without a result: the two pipelines have slipped.
            if (bus.tree_vld_o != last_tag.valid) err_q <= 1'b1;
        end
    end

    assign bus.tree_vld_i = tree_vld_q;
    assign bus.tree_din   = tree_din_q;
    assign bus.rsp_vld    = rsp_vld_q;
    assign bus.rsp_acc    = rsp_acc_q;
    assign err            = err_q;
    assign idle           = ~tree_vld_q & ~|tag_valids;

endmodule

// File: tb/tb_mac_tree_arbiter.sv
// Directed bench for mac_tree_arbiter: behavioural adder tree, expected responses queued at
// issue time and checked by an independent response monitor.
module tb_mac_tree_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 2304;
    localparam int AW  = 8;
    localparam int LAT = 8;

    logic clk = 1'b0;
    logic rstn;
    logic en;
    logic idle;
    logic err;
    logic spur;

    always #5 clk = ~clk;

    mac_tree_arbiter_if #(.NUM_REQ(NR), .DIN_W(DW), .ACC_W(AW)) bus ();

    mac_tree_arbiter #(
        .NUM_REQ  (NR),
        .DIN_W    (DW),
        .ACC_W    (AW),
        .TREE_LAT (LAT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .idle (idle),
        .err  (err),
        .bus  (bus)
    );

    // All lanes of requester r hold lane_val[r]; 144*v >>> 16 gives exp_acc[r].
    logic [15:0] lane_val [NR] = '{16'hF000, 16'h1000, 16'h7000, 16'h8000};
    logic [7:0]  exp_acc  [NR] = '{8'hF7, 8'h09, 8'h3F, 8'hB8};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int        cyc;
        logic [3:0] vld;
        logic [7:0] acc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural tree: sum of 144 signed lanes, arithmetic shift by 16, low byte.
    function automatic logic [7:0] tree_fn(input logic [DW-1:0] d);
        logic signed [31:0] s;
        s = 0;
        for (int i = 0; i < 144; i++) s += {{16{d[i*16+15]}}, d[i*16 +: 16]};
        s = s >>> 16;
        return s[7:0];
    endfunction

    logic [LAT-1:0] pv;
    logic [7:0]     pa [LAT];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv <= '0;
            for (int i = 0; i < LAT; i++) pa[i] <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], bus.tree_vld_i};
            pa[0] <= tree_fn(bus.tree_din);
            for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
        end
    end

    assign bus.tree_vld_o = pv[LAT-1] | spur;
    assign bus.tree_acc   = pa[LAT-1];

    // Response monitor.
    always @(negedge clk) begin
        if (rstn && bus.rsp_vld != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(bus.rsp_vld), 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("rsp_vld", 64'(bus.rsp_vld), 64'(e.vld));
                chk("rsp_acc", 64'(bus.rsp_acc), 64'(e.acc));
            end
        end
    end

    logic push_en;
    logic last_idle;

    // Called just after a posedge; returns just after the next posedge.
    task automatic drive(input logic [3:0] vld, input logic [3:0] exp_gnt, input logic en_v);
        exp_t e;
        bus.req_vld = vld;
        en          = en_v;
        @(negedge clk);
        chk("req_rdy", 64'(bus.req_rdy), 64'(exp_gnt));
        last_idle = idle;
        if (push_en && exp_gnt != 4'b0000) begin
            e.cyc = cyc + LAT + 2;
            e.vld = exp_gnt;
            e.acc = 8'h00;
            for (int i = 0; i < NR; i++) if (exp_gnt[i]) e.acc = exp_acc[i];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_rdy"}, 64'(bus.req_rdy), 64'h0);
        chk({tag, "_tree_vld_i"}, 64'(bus.tree_vld_i), 64'h0);
        chk({tag, "_tree_din_nz"}, 64'(|bus.tree_din), 64'h0);
        chk({tag, "_rsp_vld"}, 64'(bus.rsp_vld), 64'h0);
        chk({tag, "_rsp_acc"}, 64'(bus.rsp_acc), 64'h0);
        chk({tag, "_err"}, 64'(err), 64'h0);
        chk({tag, "_idle"}, 64'(idle), 64'h1);
    endtask

    int first_idle;

    initial begin
        rstn        = 1'b0;
        en          = 1'b0;
        spur        = 1'b0;
        push_en     = 1'b1;
        last_idle   = 1'b0;
        bus.req_vld = '0;
        for (int r = 0; r < NR; r++)
            for (int l = 0; l < 144; l++) bus.req_din[r*DW + l*16 +: 16] = lane_val[r];

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Priority with gaps from ptr=0.
        drive(4'b1010, 4'b0010, 1'b1);
        drive(4'b1011, 4'b1000, 1'b1);
        drive(4'b0011, 4'b0001, 1'b1);
        drive(4'b0011, 4'b0010, 1'b1);
        quiet(14);

        // Single request from requester 2, isolated.
        drive(4'b0100, 4'b0100, 1'b1);
        quiet(14);
        chk("idle_after_single", 64'(idle), 64'h1);

        // Requester 3 alone brings ptr back to 0.
        drive(4'b1000, 4'b1000, 1'b1);
        quiet(12);

        // Fairness: all request for 8 cycles.
        for (int k = 0; k < 8; k++) drive(4'b1111, 4'(1 << (k % 4)), 1'b1);
        // Same requester back to back.
        for (int k = 0; k < 3; k++) drive(4'b0010, 4'b0010, 1'b1);
        quiet(14);

        // Enable: three in flight, then en low.
        drive(4'b1111, 4'b0100, 1'b1);
        drive(4'b1111, 4'b1000, 1'b1);
        drive(4'b1111, 4'b0001, 1'b1);
        first_idle = -1;
        for (int k = 0; k < 13; k++) begin
            drive(4'b1111, 4'b0000, 1'b0);
            if (last_idle && first_idle < 0) first_idle = k;
        end
        chk("en_idle_seen", 64'(first_idle >= 0), 64'h1);
        chk("en_idle_bound", 64'(first_idle <= LAT + 2), 64'h1);
        quiet(2);

        // Reset mid-flight: ptr=1, five vectors issued then discarded.
        push_en = 1'b0;
        drive(4'b1111, 4'b0010, 1'b1);
        drive(4'b1111, 4'b0100, 1'b1);
        drive(4'b1111, 4'b1000, 1'b1);
        drive(4'b1111, 4'b0001, 1'b1);
        drive(4'b1111, 4'b0010, 1'b1);
        bus.req_vld = '0;
        rstn        = 1'b0;
        @(negedge clk);
        chk_reset_state("midrst");
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        push_en = 1'b1;
        drive(4'b1111, 4'b0001, 1'b1);
        quiet(14);

        // Spurious tree_vld_o with an empty tag line.
        chk("err_before", 64'(err), 64'h0);
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        @(negedge clk);
        chk("err_set", 64'(err), 64'h1);
        chk("err_rsp_vld", 64'(bus.rsp_vld), 64'h0);
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(err), 64'h1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("err_cleared", 64'(err), 64'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        quiet(2);

        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
